register_scoreboard: RTL and testbench

Issue-side hazard controller placed between the instruction decoder and the execute/memory stages. It tracks destination registers of in-flight instructions and stalls issue on RAW or WAW conflicts. It also stalls when the outstanding-write limit is reached. Writeback ports retire entries; flush clears all tracking on a redirect.

---
 rtl/register_scoreboard.sv | 67 ++++++
 tb/tb_register_scoreboard.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// register_scoreboard: issue-side RAW/WAW hazard tracker with an outstanding-write limit.
// Same-cycle writebacks bypass hazards; flush drops all tracking.
module register_scoreboard #(
   parameter int REG_ADDRESS_SIZE = 5,
   parameter int NUM_REGS = 2**REG_ADDRESS_SIZE,
   parameter int MAX_PENDING = 4,
   parameter int STALL_CNT_WIDTH = 16,
   localparam int CW = $clog2(MAX_PENDING+1)
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        issue_valid,
   output logic                        issue_ready,
   input  logic [REG_ADDRESS_SIZE-1:0] addr_r1,
   input  logic [REG_ADDRESS_SIZE-1:0] addr_r2,
   input  logic [REG_ADDRESS_SIZE-1:0] addr_rd,
   input  logic                        register_write,
   input  logic                        use_immediate,
   input  logic                        wb_valid,
   input  logic [REG_ADDRESS_SIZE-1:0] wb_addr,
   input  logic                        flush,
   output logic [NUM_REGS-1:0]         busy_mask,
   output logic [CW-1:0]               pending_count,
   output logic [1:0]                  state,
   output logic [STALL_CNT_WIDTH-1:0]  stall_count,
   output logic                        spurious_wb
);
   typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, FULL = 2'b10} state_t;
   state_t                     r_state;
   logic [NUM_REGS-1:0]        r_busy, w_wb_oh, w_busy_eff, w_busy_nxt;
   logic [CW-1:0]              r_pend, w_pend_left, w_pend_nxt;
   logic [STALL_CNT_WIDTH-1:0] r_stall;
   logic                       r_spur, w_retire, w_rd_wr, w_hazard, w_full, w_alloc, w_stall;
   assign w_wb_oh     = wb_valid ? NUM_REGS'(1) << wb_addr : '0;
   assign w_busy_eff  = r_busy & ~w_wb_oh;
   assign w_retire    = wb_valid & r_busy[wb_addr] & (wb_addr != '0);
   assign w_rd_wr     = register_write & (addr_rd != '0);
   assign w_hazard    = w_busy_eff[addr_r1] | (~use_immediate & w_busy_eff[addr_r2]) | (w_rd_wr & w_busy_eff[addr_rd]);
   assign w_pend_left = r_pend - CW'(w_retire);
   assign w_full      = w_pend_left == CW'(MAX_PENDING);
   assign issue_ready = ~flush & ~w_hazard & ~(w_full & w_rd_wr);
   assign w_alloc     = issue_valid & issue_ready & w_rd_wr;
   // clear is applied before set so a same-register alloc wins over its retire
   assign w_busy_nxt  = flush ? '0 : (r_busy & ~(w_retire ? w_wb_oh : '0)) | (w_alloc ? NUM_REGS'(1) << addr_rd : '0);
   assign w_pend_nxt  = flush ? '0 : w_pend_left + CW'(w_alloc);
   assign w_stall     = issue_valid & ~issue_ready & ~flush & ~&r_stall;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_pend  <= '0;
         r_state <= IDLE;
         r_stall <= '0;
         r_spur  <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_pend  <= w_pend_nxt;
         r_state <= w_pend_nxt == '0 ? IDLE : w_pend_nxt == CW'(MAX_PENDING) ? FULL : ACTIVE;
         r_stall <= r_stall + STALL_CNT_WIDTH'(w_stall);
         r_spur  <= r_spur | (wb_valid & ~w_retire);
      end
   end
   assign busy_mask     = r_busy;
   assign pending_count = r_pend;
   assign state         = r_state;
   assign stall_count   = r_stall;
   assign spurious_wb   = r_spur;
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed vector table, saturation/reset sequences and random
// traffic checked against an array-based scoreboard model.
module tb_register_scoreboard;
   localparam int AW = 5, NR = 32, MP = 4, SW = 4, CW = $clog2(MP+1);
   logic clk = 1'b0, rst_n;
   logic issue_valid, issue_ready, register_write, use_immediate, wb_valid, flush, spurious_wb;
   logic [AW-1:0] addr_r1, addr_r2, addr_rd, wb_addr;
   logic [NR-1:0] busy_mask;
   logic [CW-1:0] pending_count;
   logic [1:0]    state;
   logic [SW-1:0] stall_count;
   typedef struct {
      logic iv; logic [AW-1:0] r1, r2, rd; logic rw, imm, wbv; logic [AW-1:0] wba; logic fl;
      logic rdy; logic [NR-1:0] busy; int pend; int st;
   } vec_t;
   vec_t tv[20];
   vec_t v;
   bit m_busy[NR];
   int m_pend, m_stall;
   bit m_spur;
   int errs = 0, checks = 0;
   register_scoreboard #(.REG_ADDRESS_SIZE(AW), .NUM_REGS(NR), .MAX_PENDING(MP), .STALL_CNT_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .addr_r1(addr_r1), .addr_r2(addr_r2), .addr_rd(addr_rd), .register_write(register_write),
      .use_immediate(use_immediate), .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
      .busy_mask(busy_mask), .pending_count(pending_count), .state(state),
      .stall_count(stall_count), .spurious_wb(spurious_wb));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   task automatic drive(input vec_t x);
      issue_valid = x.iv; addr_r1 = x.r1; addr_r2 = x.r2; addr_rd = x.rd; register_write = x.rw;
      use_immediate = x.imm; wb_valid = x.wbv; wb_addr = x.wba; flush = x.fl;
   endtask
   function automatic bit m_eff(input int a);
      return m_busy[a] && !(wb_valid && int'(wb_addr) == a);
   endfunction
   function automatic bit m_ready();
      bit ret, haz, dst;
      ret = wb_valid && wb_addr != 0 && m_busy[wb_addr];
      dst = register_write && addr_rd != 0;
      haz = m_eff(addr_r1) || (!use_immediate && m_eff(addr_r2)) || (dst && m_eff(addr_rd));
      return !flush && !haz && !(m_pend - int'(ret) == MP && dst);
   endfunction
   function automatic logic [NR-1:0] m_mask();
      logic [NR-1:0] m = '0;
      for (int i = 0; i < NR; i++) m[i] = m_busy[i];
      return m;
   endfunction
   function automatic int m_state();
      return m_pend == 0 ? 0 : m_pend == MP ? 2 : 1;
   endfunction
   task automatic m_clear();
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_pend = 0;
   endtask
   task automatic m_step();
      bit ret, rdy, alloc;
      ret   = wb_valid && wb_addr != 0 && m_busy[wb_addr];
      rdy   = m_ready();
      alloc = issue_valid && rdy && register_write && addr_rd != 0;
      if (issue_valid && !rdy && !flush && m_stall < (1 << SW) - 1) m_stall++;
      if (wb_valid && !ret) m_spur = 1'b1;
      if (flush) m_clear();
      else begin
         if (ret) begin m_busy[wb_addr] = 1'b0; m_pend--; end
         if (alloc) begin m_busy[addr_rd] = 1'b1; m_pend++; end
      end
   endtask
   // entered at a falling edge; leaves at the next falling edge
   task automatic run(input vec_t x, input bit use_tab);
      drive(x);
      #1 chk("issue_ready", issue_ready, use_tab ? x.rdy : m_ready());
      @(posedge clk);
      m_step();
      @(negedge clk);
      chk("busy_mask", busy_mask, use_tab ? x.busy : m_mask());
      chk("pending_count", pending_count, use_tab ? x.pend : m_pend);
      chk("state", state, use_tab ? x.st : m_state());
      chk("stall_count", stall_count, m_stall);
      chk("spurious_wb", spurious_wb, m_spur);
   endtask
   initial begin
      tv[0]  = '{1, 1, 2, 3, 1, 0, 0, 0, 0, 1, 'h08, 1, 1};
      tv[1]  = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 'h08, 1, 1};
      tv[2]  = tv[1];
      tv[3]  = tv[1];
      tv[4]  = '{1, 3, 0, 3, 1, 0, 1, 3, 0, 1, 'h08, 1, 1};
      tv[5]  = '{1, 0, 3, 0, 0, 1, 0, 0, 0, 1, 'h08, 1, 1};
      tv[6]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 'h08, 1, 1};
      tv[7]  = '{0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 'h00, 0, 0};
      tv[8]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 'h02, 1, 1};
      tv[9]  = '{1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 'h06, 2, 1};
      tv[10] = '{1, 0, 0, 3, 1, 0, 0, 0, 0, 1, 'h0E, 3, 1};
      tv[11] = '{1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 'h1E, 4, 2};
      tv[12] = '{1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 'h1E, 4, 2};
      tv[13] = '{1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 'h1E, 4, 2};
      tv[14] = '{1, 0, 0, 5, 1, 0, 1, 2, 0, 1, 'h3A, 4, 2};
      tv[15] = '{0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 'h3A, 4, 2};
      tv[16] = '{0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 'h1A, 3, 1};
      tv[17] = '{1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 'h1E, 4, 2};
      tv[18] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h00, 0, 0};
      tv[19] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h00, 0, 0};
      m_clear(); m_stall = 0; m_spur = 0;
      v = '{default: 0};
      drive(v);
      rst_n = 1'b0;
      #2;
      chk("rst_busy", busy_mask, 0);
      chk("rst_pend", pending_count, 0);
      chk("rst_state", state, 0);
      chk("rst_stall", stall_count, 0);
      chk("rst_spur", spurious_wb, 0);
      chk("rst_ready", issue_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) run(tv[i], 1'b1);
      // saturate the stall counter behind a busy x1, then release it with a bypassed writeback
      v = '{default: 0}; v.iv = 1; v.rd = 1; v.rw = 1;
      run(v, 1'b0);
      v = '{default: 0}; v.iv = 1; v.r1 = 1;
      for (int i = 0; i < 16; i++) run(v, 1'b0);
      chk("stall_saturated", stall_count, 15);
      v.wbv = 1; v.wba = 1;
      drive(v);
      #1 chk("bypass_ready", issue_ready, 1);
      @(negedge clk);
      m_clear();
      v = '{default: 0}; v.fl = 1;
      run(v, 1'b0);
      for (int i = 0; i < 600; i++) begin
         v = '{default: 0};
         v.iv  = $urandom_range(0, 9) < 8;
         v.r1  = AW'($urandom_range(0, 7));
         v.r2  = AW'($urandom_range(0, 7));
         v.rd  = AW'($urandom_range(0, 7));
         v.rw  = $urandom_range(0, 9) < 7;
         v.imm = $urandom_range(0, 9) < 3;
         v.wbv = $urandom_range(0, 9) < 4;
         v.wba = AW'($urandom_range(0, 7));
         v.fl  = $urandom_range(0, 99) < 3;
         run(v, 1'b0);
      end
      v = '{default: 0}; v.iv = 1; v.rd = 6; v.rw = 1; v.r1 = 6;
      run(v, 1'b0);
      v = '{default: 0};
      drive(v);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy_mask, 0);
      chk("mid_rst_pend", pending_count, 0);
      chk("mid_rst_state", state, 0);
      chk("mid_rst_stall", stall_count, 0);
      chk("mid_rst_spur", spurious_wb, 0);
      chk("mid_rst_ready", issue_ready, 1);
      m_clear(); m_stall = 0; m_spur = 0;
      @(negedge clk);
      rst_n = 1'b1;
      v.wbv = 1; v.wba = 6;
      run(v, 1'b0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
